// File: rtl/spi_sbus_master.sv
// spi_sbus_master: system-bus master for the iCE40 SB_SPI hard IP.
// After reset it configures the core (CR1, CR2, BR). It then turns each
// upstream command byte into the register sequence CS on, TRDY poll,
// TXDR write, RRDY poll, RXDR read and, for the last byte, CS off.
// Optional feature macro: SPI_SBUS_TIMEOUT_EN adds a bus-ack watchdog and
// a sticky error flag. Without it, error is tied low.
module spi_sbus_master #(
    parameter logic [3:0] BUS_ADDR74 = 4'b0000,
    parameter logic [5:0] BR_DIV     = 6'd12,
    parameter logic [1:0] SPI_MODE   = 2'd0,
    parameter int         POLL_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_last,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       init_done,
    output logic       busy,
    output logic       error,
    output logic       sb_stb,
    output logic       sb_rw,
    output logic [7:0] sb_addr,
    output logic [7:0] sb_wdata,
    input  logic [7:0] sb_rdata,
    input  logic       sb_ack
);

    // FSM encoding
    localparam logic [3:0] ST_INIT_CR1 = 4'd0;
    localparam logic [3:0] ST_INIT_CR2 = 4'd1;
    localparam logic [3:0] ST_INIT_BR  = 4'd2;
    localparam logic [3:0] ST_IDLE     = 4'd3;
    localparam logic [3:0] ST_CS_ON    = 4'd4;
    localparam logic [3:0] ST_POLL_T   = 4'd5;
    localparam logic [3:0] ST_WR_TX    = 4'd6;
    localparam logic [3:0] ST_POLL_R   = 4'd7;
    localparam logic [3:0] ST_RD_RX    = 4'd8;
    localparam logic [3:0] ST_CS_OFF   = 4'd9;

    // SB_SPI register offsets (low address nibble)
    localparam logic [3:0] OFF_CR1  = 4'h9;
    localparam logic [3:0] OFF_CR2  = 4'hA;
    localparam logic [3:0] OFF_BR   = 4'hB;
    localparam logic [3:0] OFF_SR   = 4'hC;
    localparam logic [3:0] OFF_TXDR = 4'hD;
    localparam logic [3:0] OFF_RXDR = 4'hE;
    localparam logic [3:0] OFF_CSR  = 4'hF;

    // The gap counter is loaded with POLL_GAP-1. The launch cycle itself is idle,
    // so a failed poll is followed by exactly POLL_GAP idle cycles.
    localparam int         GAP_M1     = (POLL_GAP > 1) ? (POLL_GAP - 1) : 0;
    localparam logic [7:0] GAP_RELOAD = GAP_M1[7:0];

    logic [3:0] state_q, state_d;
    logic       stb_q, stb_d;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] byte_q, byte_d;
    logic       last_q, last_d;
    logic       cs_held_q, cs_held_d;
    logic       busy_q, busy_d;
    logic       init_done_q, init_done_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
`ifdef SPI_SBUS_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;
    logic       error_q, error_d;
`endif

    logic       acc_rw_s;
    logic [3:0] acc_off_s;
    logic [7:0] acc_wdata_s;

    // Decode which bus access the current state performs
    always_comb begin
        acc_rw_s    = 1'b0;
        acc_off_s   = 4'h0;
        acc_wdata_s = 8'h00;
        case (state_q)
            ST_INIT_CR1: begin acc_rw_s = 1'b1; acc_off_s = OFF_CR1;  acc_wdata_s = 8'h80; end
            ST_INIT_CR2: begin acc_rw_s = 1'b1; acc_off_s = OFF_CR2;  acc_wdata_s = {1'b1, 1'b1, 3'b000, SPI_MODE, 1'b0}; end
            ST_INIT_BR:  begin acc_rw_s = 1'b1; acc_off_s = OFF_BR;   acc_wdata_s = {2'b00, BR_DIV}; end
            ST_CS_ON:    begin acc_rw_s = 1'b1; acc_off_s = OFF_CSR;  acc_wdata_s = 8'h01; end
            ST_POLL_T:   begin acc_rw_s = 1'b0; acc_off_s = OFF_SR;   acc_wdata_s = 8'h00; end
            ST_WR_TX:    begin acc_rw_s = 1'b1; acc_off_s = OFF_TXDR; acc_wdata_s = byte_q; end
            ST_POLL_R:   begin acc_rw_s = 1'b0; acc_off_s = OFF_SR;   acc_wdata_s = 8'h00; end
            ST_RD_RX:    begin acc_rw_s = 1'b0; acc_off_s = OFF_RXDR; acc_wdata_s = 8'h00; end
            ST_CS_OFF:   begin acc_rw_s = 1'b1; acc_off_s = OFF_CSR;  acc_wdata_s = 8'h00; end
            default:     begin acc_rw_s = 1'b0; acc_off_s = 4'h0;     acc_wdata_s = 8'h00; end
        endcase
    end

    // Next-state logic: command accept, bus access engine and sequencing
    always_comb begin
        state_d     = state_q;
        stb_d       = stb_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        gap_d       = gap_q;
        byte_d      = byte_q;
        last_d      = last_q;
        cs_held_d   = cs_held_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef SPI_SBUS_TIMEOUT_EN
        wd_d        = wd_q;
        error_d     = error_q;
`endif
        if (state_q == ST_IDLE) begin
            if (cmd_ready_q && cmd_valid) begin
                byte_d  = cmd_data;
                last_d  = cmd_last;
                busy_d  = 1'b1;
                state_d = cs_held_q ? ST_POLL_T : ST_CS_ON;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (stb_q) begin
            if (sb_ack) begin
                // Access completes; stb drops on the following cycle
                stb_d = 1'b0;
                gap_d = 8'd0;
`ifdef SPI_SBUS_TIMEOUT_EN
                wd_d  = 8'd0;
`endif
                case (state_q)
                    ST_INIT_CR1: state_d = ST_INIT_CR2;
                    ST_INIT_CR2: state_d = ST_INIT_BR;
                    ST_INIT_BR: begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end
                    ST_CS_ON: begin
                        state_d   = ST_POLL_T;
                        cs_held_d = 1'b1;
                    end
                    ST_POLL_T: begin
                        if (sb_rdata[4]) begin
                            state_d = ST_WR_TX;
                        end else begin
                            gap_d = GAP_RELOAD;
                        end
                    end
                    ST_WR_TX: state_d = ST_POLL_R;
                    ST_POLL_R: begin
                        if (sb_rdata[3]) begin
                            state_d = ST_RD_RX;
                        end else begin
                            gap_d = GAP_RELOAD;
                        end
                    end
                    ST_RD_RX: begin
                        rsp_data_d  = sb_rdata;
                        rsp_valid_d = 1'b1;
                        state_d     = last_q ? ST_CS_OFF : ST_IDLE;
                    end
                    ST_CS_OFF: begin
                        state_d   = ST_IDLE;
                        cs_held_d = 1'b0;
                        busy_d    = 1'b0;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end else begin
`ifdef SPI_SBUS_TIMEOUT_EN
                // The CS release write is never timed out, so the core is always left deselected.
                if ((state_q != ST_CS_OFF) && (wd_q == 8'hFF)) begin
                    stb_d   = 1'b0;
                    error_d = 1'b1;
                    wd_d    = 8'd0;
                    gap_d   = 8'd0;
                    state_d = ST_CS_OFF;
                end else if (state_q != ST_CS_OFF) begin
                    wd_d = wd_q + 8'd1;
                end else begin
                    wd_d = wd_q;
                end
`else
                stb_d = 1'b1;
`endif
            end
        end else if (gap_q != 8'd0) begin
            gap_d = gap_q - 8'd1;
        end else begin
            // Launch the access for this state; fields stay frozen until ack
            stb_d   = 1'b1;
            rw_d    = acc_rw_s;
            addr_d  = {BUS_ADDR74, acc_off_s};
            wdata_d = acc_wdata_s;
        end
        // A command cannot be taken in the same cycle as the response pulse
        cmd_ready_d = (state_d == ST_IDLE) && init_done_d && !rsp_valid_d;
    end

    // State and registered outputs with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT_CR1;
            stb_q       <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            gap_q       <= 8'd0;
            byte_q      <= 8'h00;
            last_q      <= 1'b0;
            cs_held_q   <= 1'b0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
`ifdef SPI_SBUS_TIMEOUT_EN
            wd_q        <= 8'd0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            stb_q       <= stb_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gap_q       <= gap_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            cs_held_q   <= cs_held_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef SPI_SBUS_TIMEOUT_EN
            wd_q        <= wd_d;
            error_q     <= error_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;
    assign sb_stb    = stb_q;
    assign sb_rw     = rw_q;
    assign sb_addr   = addr_q;
    assign sb_wdata  = wdata_q;
`ifdef SPI_SBUS_TIMEOUT_EN
    assign error     = error_q;
`else
    assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sbus_master.sv
// Directed testbench for spi_sbus_master with a behavioural SB_SPI model.
// The model acks after 2 cycles, loops TXDR back to RXDR, and can stall SR bits.
module tb_spi_sbus_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_last = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       init_done;
    logic       busy;
    logic       error;
    logic       sb_stb;
    logic       sb_rw;
    logic [7:0] sb_addr;
    logic [7:0] sb_wdata;
    logic [7:0] sb_rdata = 8'h00;
    logic       sb_ack = 1'b0;

    spi_sbus_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_last(cmd_last),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .init_done(init_done), .busy(busy), .error(error),
        .sb_stb(sb_stb), .sb_rw(sb_rw), .sb_addr(sb_addr), .sb_wdata(sb_wdata),
        .sb_rdata(sb_rdata), .sb_ack(sb_ack)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // SB_SPI model state and access log
    int         wait_cnt = 0;
    int         trdy_block = 0;
    int         rrdy_block = 0;
    bit         noack_txdr = 1'b0;
    logic [7:0] txdr_m = 8'h00;
    int         log_n = 0;
    logic       log_rw   [0:511];
    logic [7:0] log_addr [0:511];
    logic [7:0] log_data [0:511];
    int         log_idle [0:511];
    int         idle_cnt = 0;
    int         start_idle = 0;
    logic       prev_stb = 1'b0;
    logic       p_rw = 1'b0;
    logic [7:0] p_addr = 8'h00;
    logic [7:0] p_wdata = 8'h00;
    int         unstable = 0;
    int         rsp_cnt = 0;
    int         ready_in_rsp = 0;
    logic [7:0] rsp_last = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural SB_SPI and bus monitor, evaluated on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            sb_ack   = 1'b0;
            wait_cnt = 0;
            prev_stb = 1'b0;
            idle_cnt = 0;
        end else begin
            if (sb_stb && prev_stb && (sb_addr != p_addr || sb_rw != p_rw || sb_wdata != p_wdata))
                unstable++;
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_last = rsp_data;
                if (cmd_ready) ready_in_rsp++;
            end
            if (sb_stb && !prev_stb) begin
                start_idle = idle_cnt;
                idle_cnt   = 0;
            end
            if (!sb_stb) idle_cnt++;
            if (sb_ack) begin
                sb_ack = 1'b0;
            end else if (sb_stb) begin
                wait_cnt++;
                if (wait_cnt >= 2 && !(noack_txdr && sb_addr[3:0] == 4'hD)) begin
                    sb_ack   = 1'b1;
                    wait_cnt = 0;
                    if (!sb_rw && sb_addr[3:0] == 4'hC) begin
                        sb_rdata = {3'b000, (trdy_block == 0), (rrdy_block == 0), 3'b000};
                        if (trdy_block > 0) trdy_block--;
                        if (rrdy_block > 0) rrdy_block--;
                    end else if (!sb_rw && sb_addr[3:0] == 4'hE) begin
                        sb_rdata = txdr_m;
                    end else begin
                        sb_rdata = 8'h00;
                    end
                    if (sb_rw && sb_addr[3:0] == 4'hD) txdr_m = sb_wdata;
                    if (log_n < 512) begin
                        log_rw[log_n]   = sb_rw;
                        log_addr[log_n] = sb_addr;
                        log_data[log_n] = sb_rw ? sb_wdata : sb_rdata;
                        log_idle[log_n] = start_idle;
                        log_n++;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
            prev_stb = sb_stb;
            p_rw     = sb_rw;
            p_addr   = sb_addr;
            p_wdata  = sb_wdata;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_log(input string tag, input int idx, input logic rw, input logic [7:0] a, input logic [7:0] d);
        logic [31:0] obs;
        if (idx < log_n) obs = {15'd0, log_rw[idx], log_addr[idx], log_data[idx]};
        else obs = 32'hDEAD_BEEF;
        check(tag, obs, {15'd0, rw, a, d});
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            tick();
        end
        check("send_ready_wait", {31'd0, ok}, 32'd1);
        cmd_valid = 1'b1;
        cmd_data  = b;
        cmd_last  = last;
        tick();
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
    endtask

    task automatic wait_rsp(input int prev);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (rsp_cnt > prev) begin ok = 1'b1; break; end
            tick();
        end
        check("rsp_wait", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (cmd_ready && !busy) begin ok = 1'b1; break; end
            tick();
        end
        check("idle_wait", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_init();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (init_done) begin ok = 1'b1; break; end
            tick();
        end
        check("init_wait", {31'd0, ok}, 32'd1);
        tick();
    endtask

    // Safety net so the run always terminates
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    // Directed test sequence
    initial begin
        int         base;
        int         prev;
        int         n01;
        int         n00;
        int         nsr;
        int         min_gap;
        logic [7:0] first_rsp;
        logic [7:0] exp_a [0:5];
        logic [7:0] exp_d [0:5];
        logic       exp_w [0:5];

        // Reset state
        repeat (3) tick();
        check("reset_outputs",
              {6'd0, sb_stb, sb_rw, sb_addr, sb_wdata, cmd_ready, rsp_valid, init_done, busy, error, 3'd0},
              32'd0);
        check("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
        rst = 1'b0;

        // Init sequence
        wait_init();
        check_log("init_cr1", 0, 1'b1, 8'h09, 8'h80);
        check_log("init_cr2", 1, 1'b1, 8'h0A, 8'hC0);
        check_log("init_br",  2, 1'b1, 8'h0B, 8'h0C);
        check("init_ready", {31'd0, cmd_ready}, 32'd1);
        check("init_busy",  {31'd0, busy}, 32'd0);

        // Single byte with loopback
        base = log_n;
        prev = rsp_cnt;
        send(8'hA5, 1'b1);
        wait_rsp(prev);
        check("single_rsp_data", {24'd0, rsp_last}, 32'h0000_00A5);
        wait_idle();
        exp_w = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_a = '{8'h0F, 8'h0C, 8'h0D, 8'h0C, 8'h0E, 8'h0F};
        exp_d = '{8'h01, 8'h18, 8'hA5, 8'h18, 8'hA5, 8'h00};
        for (int i = 0; i < 6; i++)
            check_log($sformatf("single_acc%0d", i), base + i, exp_w[i], exp_a[i], exp_d[i]);
        check("single_acc_count", log_n - base, 32'd6);
        check("single_rsp_count", rsp_cnt - prev, 32'd1);
        check("single_busy_end",  {31'd0, busy}, 32'd0);

        // Three-byte burst with CS held throughout
        base = log_n;
        prev = rsp_cnt;
        send(8'h9F, 1'b0);
        wait_rsp(prev);
        first_rsp = rsp_last;
        tick();
        check("burst_busy_held", {31'd0, busy}, 32'd1);
        send(8'h00, 1'b0);
        wait_rsp(prev + 1);
        send(8'h00, 1'b1);
        wait_rsp(prev + 2);
        wait_idle();
        n01 = 0;
        n00 = 0;
        for (int i = base; i < log_n; i++) begin
            if (log_rw[i] && log_addr[i] == 8'h0F && log_data[i] == 8'h01) n01++;
            if (log_rw[i] && log_addr[i] == 8'h0F && log_data[i] == 8'h00) n00++;
        end
        check("burst_cs_on_writes",  n01, 32'd1);
        check("burst_cs_off_writes", n00, 32'd1);
        check("burst_rsp_count", rsp_cnt - prev, 32'd3);
        check("burst_first_rsp", {24'd0, first_rsp}, 32'h0000_009F);
        check("burst_last_rsp",  {24'd0, rsp_last}, 32'h0000_0000);
        check_log("burst_final_cs_off", log_n - 1, 1'b1, 8'h0F, 8'h00);

        // TRDY held low for 5 polls
        base = log_n;
        prev = rsp_cnt;
        trdy_block = 5;
        send(8'h3C, 1'b1);
        wait_rsp(prev);
        wait_idle();
        nsr = 0;
        min_gap = 1000;
        for (int i = base; i < log_n; i++) begin
            if (log_addr[i] == 8'h0C) begin
                nsr++;
                if (i > base && log_addr[i-1] == 8'h0C && log_idle[i] < min_gap) min_gap = log_idle[i];
            end
        end
        check("trdy_sr_reads", nsr, 32'd7);
        check("trdy_poll_gap", {31'd0, (min_gap >= 4)}, 32'd1);
        check("trdy_rsp_data", {24'd0, rsp_last}, 32'h0000_003C);

        // Reset while polling RRDY
        base = log_n;
        rrdy_block = 1000;
        send(8'h55, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (log_n >= base + 3) break;
            tick();
        end
        repeat (12) tick();
        check_log("rst_reached_txdr", base + 2, 1'b1, 8'h0D, 8'h55);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs",
              {6'd0, sb_stb, sb_rw, sb_addr, sb_wdata, cmd_ready, rsp_valid, init_done, busy, error, 3'd0},
              32'd0);
        repeat (2) tick();
        rrdy_block = 0;
        prev = rsp_cnt;
        base = log_n;
        rst = 1'b0;
        wait_init();
        check_log("rerun_cr1", base,     1'b1, 8'h09, 8'h80);
        check_log("rerun_cr2", base + 1, 1'b1, 8'h0A, 8'hC0);
        check_log("rerun_br",  base + 2, 1'b1, 8'h0B, 8'h0C);
        repeat (5) tick();
        check("rerun_no_stale_rsp", rsp_cnt - prev, 32'd0);
        check("rerun_ready", {31'd0, cmd_ready}, 32'd1);

`ifdef SPI_SBUS_TIMEOUT_EN
        // TXDR never acknowledged
        base = log_n;
        prev = rsp_cnt;
        noack_txdr = 1'b1;
        send(8'h77, 1'b1);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                if (error) begin ok = 1'b1; break; end
                tick();
            end
            check("timeout_error_wait", {31'd0, ok}, 32'd1);
        end
        wait_idle();
        noack_txdr = 1'b0;
        check("timeout_error_sticky", {31'd0, error}, 32'd1);
        check_log("timeout_cs_off", log_n - 1, 1'b1, 8'h0F, 8'h00);
        check("timeout_no_rsp", rsp_cnt - prev, 32'd0);
`else
        check("error_tied_low", {31'd0, error}, 32'd0);
`endif

        check("bus_fields_stable", unstable, 32'd0);
        check("ready_during_rsp", ready_in_rsp, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_sbus_master.md
Name: spi_sbus_master

Overview:
- System-bus master that drives the iCE40 SB_SPI hard IP register interface on behalf of a simple byte-stream client.
- Brings the SPI core up after reset, then turns each upstream command byte into the SB register sequence: assert CS, wait TRDY, write TXDR, wait RRDY, read RXDR, release CS.
- Sits directly upstream of SB_SPI (feeds SBSTBI/SBRWI/SBADRI/SBDATI, consumes SBDATO/SBACKO) and replaces the hand-written bus master in the SPI top level.

Parameters:
- BUS_ADDR74, 4'b0000, upper address nibble of the target SB_SPI instance; must match its BUS_ADDR74.
- BR_DIV, 6'd12, SPIBR divider value; SCK = clk/(BR_DIV+1).
- SPI_MODE, 2'd0, {CPOL,CPHA}, written into SPICR2[2:1].
- POLL_GAP, 4, idle cycles between consecutive SPISR polls (minimum 1).

Ports:
- clk  in  1  system clock (27 MHz)
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command byte valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_data  in  8  byte to transmit on MOSI
- cmd_last  in  1  release CS after this byte
- rsp_valid  out  1  one-cycle pulse: received byte available
- rsp_data  out  8  byte captured from MISO, held until the next rsp_valid
- init_done  out  1  SPI core configured
- busy  out  1  transfer in progress (CS asserted or bus access pending)
- error  out  1  sticky bus timeout flag (only when the optional feature is compiled in; otherwise tied 0)
- sb_stb  out  1  SB strobe
- sb_rw  out  1  1 = write, 0 = read
- sb_addr  out  8  {BUS_ADDR74, reg offset}
- sb_wdata  out  8  write data
- sb_rdata  in  8  read data from SB_SPI
- sb_ack  in  1  SB acknowledge

Behaviour:
- Register offsets: CR1 = 0x9, CR2 = 0xA, BR = 0xB, SR = 0xC, TXDR = 0xD, RXDR = 0xE, CSR = 0xF.
- SR bits used: TRDY = bit4, RRDY = bit3.
- Reset values: all outputs 0; state = INIT_CR1.
- Bus access rule:
  - Set stb = 1 with rw/addr/wdata stable; hold all of them until the cycle in which sb_ack = 1.
  - Drop stb the cycle after ack; at least one idle cycle between accesses.
  - Read data is captured in the ack cycle.
- State sequence:
  - INIT_CR1: write 0x80 (SPE).
  - INIT_CR2: write {1'b1 MSTR, 1'b1 MCSH, 3'b000, SPI_MODE, 1'b0}.
  - INIT_BR: write {2'b00, BR_DIV}.
  - Then init_done = 1 and go to IDLE.
  - IDLE: cmd_ready = 1. On accept, latch cmd_data/cmd_last and set busy = 1.
    - If CS is already asserted from a previous byte without last → POLL_T.
    - Otherwise → CS_ON.
  - CS_ON: write CSR = 0x01 (CSN0 low).
  - POLL_T: read SR; repeat after POLL_GAP idle cycles until TRDY = 1.
  - WR_TX: write TXDR = latched byte.
  - POLL_R: read SR until RRDY = 1.
  - RD_RX: read RXDR. Next cycle: rsp_data = value, rsp_valid pulse.
    - If last → CS_OFF.
    - Otherwise → IDLE, with CS still held and busy = 1.
  - CS_OFF: write CSR = 0x00, then go to IDLE with busy = 0.
- cmd_ready = 0 in every state except IDLE, and remains 0 until init_done = 1.
- Exactly one byte is in flight; there is no buffering. Back-to-back commands keep CS asserted; SCK gaps between bytes are permitted.
- A command presented in the same cycle as rsp_valid is not accepted; it is accepted at the earliest one cycle later.
- Reset mid-operation: all state clears immediately, stb drops, and the init sequence reruns. The SB_SPI core is assumed reset by the same rst.

Optional Feature:
- Macro: SPI_SBUS_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts cycles with stb = 1 and no ack.
  - At 255 it drops stb, sets error = 1 (sticky until rst), and forces CS_OFF then IDLE.
  - The CS_OFF write is itself not timed out.
  - rsp_valid is not pulsed for an aborted byte.
- Undefined: no counter logic is generated; error is tied 0; the block waits for ack indefinitely.

Test Plan:
- Reset release with an SB_SPI behavioural model (ack after 2 cycles) → writes CR1 = 0x80, CR2 = 0xC0, BR = 0x0C at addresses 0x09/0x0A/0x0B in order; init_done = 1; cmd_ready = 1.
- Single byte 0xA5, last = 1, model loops MOSI→MISO → access order CSR = 0x01, SR polls, TXDR = 0xA5, SR polls, RXDR read; rsp_valid once with rsp_data = 0xA5; CSR = 0x00; busy = 0.
- Three bytes 0x9F, 0x00, 0x00 (last on third) → exactly one CSR = 0x01 and one CSR = 0x00 write; three rsp_valid pulses; CS held throughout.
- Model returns TRDY = 0 for 5 polls → 5 extra SR reads, each separated by ≥ POLL_GAP idle cycles; stb/addr stable during every access.
- rst asserted while in POLL_R → outputs 0 immediately; after release, the init sequence repeats and no stale rsp_valid appears.
- With SPI_SBUS_TIMEOUT_EN defined, model never acks TXDR → error = 1 after 255 cycles; CSR = 0x00 written; cmd_ready returns to 1; no rsp_valid.
